// File: rtl/if_id_queue_pkg.sv
// Shared constants and helpers for the IF->ID decoupling queue and its pointer controller.
package if_id_queue_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // Occupancy update selected by the qualified {push, pop} pair
    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_fifo_ptr_ctrl.sv
// Read/write pointers, occupancy count and full/empty flags for a power-of-2 FIFO.
// Requests are qualified here so that flush and full/empty gate every storage update.
module fifo_ptr_ctrl
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;
    fifo_op_e         op;

    // Flags come from registered count only, so no request reaches them combinationally
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign push = push_req & ~full  & ~flush;
    assign pop  = pop_req  & ~empty & ~flush;
    assign op   = fifo_op_e'({push, pop});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush == ChipEnable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (op)
                OpPush: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                end
                OpPop: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
                OpBoth: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: buffers up to DEPTH {pc, inst} pairs and presents the oldest to
// decode, or an all-zero bubble when empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic            push;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            full;
    logic            empty;
    logic [DEPTH-1:0] wr_en;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PtrW),
        .CNT_W (CNT_W)
    ) u_ptr_ctrl (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_req (if_valid),
        .pop_req  (id_ready),
        .push     (push),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i] = push && (wr_ptr == PtrW'(i));
        end
    end

    // Storage is left unreset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                pc_mem_q[i]   <= if_pc;
                inst_mem_q[i] <= if_inst;
            end
        end
    end

    assign if_ready = full  ? ChipDisable : ChipEnable;
    assign id_valid = empty ? ChipDisable : ChipEnable;

    always_comb begin
        id_pc   = '0;
        id_inst = '0;
        if (!empty) begin
            id_pc   = pc_mem_q[rd_ptr];
            id_inst = inst_mem_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model.
module tb_if_id_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst, flush, if_valid, id_ready;
    logic              if_ready, id_valid;
    logic [ADDR_W-1:0] if_pc, id_pc;
    logic [INST_W-1:0] if_inst, id_inst;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int errors = 0;

    // Reference model: entries as {pc, inst}
    logic [63:0] model_q[$];

    if_id_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check outputs against the model mid-cycle, then advance DUT and model by one edge
    task automatic step();
        int  sz;
        bit  do_push, do_pop;
        @(negedge clk);
        sz = model_q.size();
        check_eq("count", 64'(count), 64'(sz));
        check_eq("count_range", 64'(count <= CNT_W'(DEPTH)), 64'd1);
        check_eq("if_ready", 64'(if_ready), 64'(sz < DEPTH));
        check_eq("id_valid", 64'(id_valid), 64'(sz > 0));
        check_eq("id_pc", 64'(id_pc), (sz > 0) ? 64'(model_q[0][63:32]) : 64'd0);
        check_eq("id_inst", 64'(id_inst), (sz > 0) ? 64'(model_q[0][31:0]) : 64'd0);
        do_push = if_valid && (sz < DEPTH) && !flush;
        do_pop  = id_ready && (sz > 0) && !flush;
        @(posedge clk);
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({if_pc, if_inst});
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit r, input logic [31:0] pc);
        if_valid = v;
        id_ready = r;
        if_pc    = pc;
        if_inst  = pc ^ 32'hA5A5_0013;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0);

        // 1: reset
        repeat (2) step();
        rst = 1'b0;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_if_ready", 64'(if_ready), 64'd1);
        check_eq("rst_id_valid", 64'(id_valid), 64'd0);
        check_eq("rst_id_pc", 64'(id_pc), 64'd0);
        check_eq("rst_id_inst", 64'(id_inst), 64'd0);

        // 2: fill while stalled; fifth offer refused
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(4 * i));
            step();
        end
        check_eq("full_count", 64'(count), 64'd4);
        check_eq("full_if_ready", 64'(if_ready), 64'd0);
        check_eq("full_head", 64'(id_pc), 64'h100);

        // 3: drain
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 32'h0);
            if (i < 4) check_eq("drain_pc", 64'(id_pc), 64'h100 + 64'(4 * i));
            step();
        end
        check_eq("drain_valid", 64'(id_valid), 64'd0);
        check_eq("drain_inst", 64'(id_inst), 64'd0);

        // 4: streaming push+pop with pointer wrap
        drive(1'b1, 1'b0, 32'h200);
        step();
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            drive(1'b1, 1'b1, 32'h200 + 32'(4 * i));
            check_eq("stream_pc", 64'(id_pc), 64'h200 + 64'(4 * (i - 1)));
            step();
            check_eq("stream_count", 64'(count), 64'd1);
        end

        // 5: flush with simultaneous push and pop
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h300 + 32'(4 * i));
            step();
        end
        check_eq("pre_flush_count", 64'(count), 64'd3);
        drive(1'b1, 1'b1, 32'h0000_0BAD);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_valid", 64'(id_valid), 64'd0);
        step();
        check_eq("flush_no_leak", 64'(id_pc == 32'h0000_0BAD), 64'd0);

        // 6: reset mid-operation while pushing
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h400 + 32'(4 * i));
            step();
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h408);
        step();
        rst = 1'b0;
        check_eq("rst_mid_count", 64'(count), 64'd0);
        check_eq("rst_mid_valid", 64'(id_valid), 64'd0);
        drive(1'b1, 1'b0, 32'h500);
        step();
        check_eq("resume_count", 64'(count), 64'd1);
        check_eq("resume_pc", 64'(id_pc), 64'h500);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if_valid = 1'($urandom_range(0, 3) != 0);
            id_ready = 1'($urandom_range(0, 2) != 0);
            flush    = 1'($urandom_range(0, 15) == 0);
            rst      = 1'($urandom_range(0, 63) == 0);
            if_pc    = $urandom;
            if_inst  = $urandom;
            step();
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
